// File: rtl/spot_sched_pkg.sv
// rtl/spot_sched_pkg.sv - shared types and constants for the spot bank scheduler
package spot_sched_pkg;

   localparam int ROI_COORD_BITS   = 10;
   localparam int ROI_BITS         = 4 * ROI_COORD_BITS;
   localparam int NUM_ROIS_MAX_DEF = 10;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_START   = 2'd1,
      S_BUSY    = 2'd2,
      S_PUBLISH = 2'd3
   } sched_state_t;

   // Spot finder may report more ROIs than the bus can carry.
   function automatic logic [7:0] clamp_rois(input logic [7:0] n, input int max_rois);
      if (int'(n) > max_rois) return 8'(max_rois);
      return n;
   endfunction

endpackage

// File: rtl/spot_bank_scheduler_if.sv
// rtl/spot_bank_scheduler_if.sv - camera / spot finder / result bundle of the bank scheduler
interface spot_bank_scheduler_if #(
   parameter int NUM_ROIS_MAX = spot_sched_pkg::NUM_ROIS_MAX_DEF
);
   localparam int RW = NUM_ROIS_MAX * spot_sched_pkg::ROI_BITS;

   logic          frame_done;
   logic          wr_bank;
   logic          sf_bank;
   logic          sf_start;
   logic          sf_abort;
   logic          sf_rdy;
   logic [7:0]    sf_num_rois;
   logic [RW-1:0] sf_rois;
   logic [RW-1:0] rois_out;
   logic [7:0]    num_rois_out;
   logic          rois_valid;
   logic [15:0]   frames_dropped;
   logic          timeout_err;

   modport master (
      input  frame_done, sf_rdy, sf_num_rois, sf_rois,
      output wr_bank, sf_bank, sf_start, sf_abort, rois_out, num_rois_out,
             rois_valid, frames_dropped, timeout_err
   );

   modport slave (
      output frame_done, sf_rdy, sf_num_rois, sf_rois,
      input  wr_bank, sf_bank, sf_start, sf_abort, rois_out, num_rois_out,
             rois_valid, frames_dropped, timeout_err
   );

endinterface

// File: rtl/spot_watchdog.sv
// rtl/spot_watchdog.sv - BUSY-phase cycle counter; expire_o marks the LIMIT-th running cycle
module spot_watchdog #(
   parameter int LIMIT = 1000000
) (
   input  logic clk_in,
   input  logic reset,
   input  logic run_i,
   input  logic clear_i,
   output logic expire_o
);
   localparam int            W    = $clog2(LIMIT + 1);
   localparam logic [W-1:0]  LAST = W'(LIMIT - 1);

   logic [W-1:0] count_q, count_d;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   always_comb begin
      count_d = count_q;
      if (clear_i)                       count_d = '0;
      else if (run_i && count_q != LAST) count_d = count_q + 1'b1;
   end

   assign expire_o = run_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/spot_bank_scheduler.sv
// rtl/spot_bank_scheduler.sv - ping-pong frame bank scheduler between camera writer and spot finder
// Define SPOT_SCHED_TIMEOUT_EN to add the BUSY watchdog (sf_abort / timeout_err).
module spot_bank_scheduler
   import spot_sched_pkg::*;
#(
   parameter int NUM_ROIS_MAX   = NUM_ROIS_MAX_DEF,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                 clk_in,
   input  logic                 reset,
   spot_bank_scheduler_if.master bus
);
   localparam int RW = NUM_ROIS_MAX * ROI_BITS;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   sched_state_t  state_q, state_d;
   logic          wr_bank_q, wr_bank_d;
   logic          sf_bank_q, sf_bank_d;
   logic          sf_abort_q, sf_abort_d;
   logic          timeout_err_q, timeout_err_d;
   logic [15:0]   dropped_q, dropped_d;
   logic [7:0]    num_rois_q, num_rois_d;
   logic [RW-1:0] rois_q, rois_d;

   logic in_busy, frame_swap, frame_drop, wd_expire;

   assign in_busy    = (state_q == S_BUSY);
   assign frame_swap = bus.frame_done && (state_q == S_IDLE || state_q == S_PUBLISH);
   assign frame_drop = bus.frame_done && (state_q == S_START || state_q == S_BUSY);

`ifdef SPOT_SCHED_TIMEOUT_EN
   spot_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
      .clk_in   (clk_in),
      .reset    (reset),
      .run_i    (in_busy),
      .clear_i  (!in_busy),
      .expire_o (wd_expire)
   );
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         wr_bank_q     <= 1'b0;
         sf_bank_q     <= 1'b1;
         sf_abort_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         dropped_q     <= '0;
         num_rois_q    <= '0;
         rois_q        <= '0;
      end else begin
         state_q       <= state_d;
         wr_bank_q     <= wr_bank_d;
         sf_bank_q     <= sf_bank_d;
         sf_abort_q    <= sf_abort_d;
         timeout_err_q <= timeout_err_d;
         dropped_q     <= dropped_d;
         num_rois_q    <= num_rois_d;
         rois_q        <= rois_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_bank_d  = wr_bank_q;
      sf_bank_d  = sf_bank_q;
      dropped_d  = dropped_q;
      num_rois_d = num_rois_q;
      rois_d     = rois_q;
      case (state_q)
         S_IDLE:    if (bus.frame_done) state_d = S_START;
         S_START:   state_d = S_BUSY;
         S_BUSY:    if (bus.sf_rdy)     state_d = S_PUBLISH;
                    else if (wd_expire) state_d = S_IDLE;
         S_PUBLISH: state_d = bus.frame_done ? S_START : S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      // The finder takes the bank just written; the camera moves to the other one.
      if (frame_swap) begin
         wr_bank_d = ~wr_bank_q;
         sf_bank_d = wr_bank_q;
      end
      if (frame_drop && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
      // Results are captured with sf_rdy so they are stable during the rois_valid cycle.
      if (in_busy && bus.sf_rdy) begin
         rois_d     = bus.sf_rois;
         num_rois_d = clamp_rois(bus.sf_num_rois, NUM_ROIS_MAX);
      end
      sf_abort_d    = in_busy && !bus.sf_rdy && wd_expire;
      timeout_err_d = timeout_err_q | sf_abort_d;
   end

   always_comb begin
      bus.sf_start       = (state_q == S_START);
      bus.rois_valid     = (state_q == S_PUBLISH);
      bus.wr_bank        = wr_bank_q;
      bus.sf_bank        = sf_bank_q;
      bus.sf_abort       = sf_abort_q;
      bus.timeout_err    = timeout_err_q;
      bus.frames_dropped = dropped_q;
      bus.num_rois_out   = num_rois_q;
      bus.rois_out       = rois_q;
   end

endmodule

// File: doc/spot_bank_scheduler.md
SPOT_BANK_SCHEDULER -- requirements
Module: spot_bank_scheduler

Interface
REQ-001 Parameter NUM_ROIS_MAX, default 10, maximum ROIs per frame; sets ROI bus width NUM_ROIS_MAX*40.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, watchdog limit in clk_in cycles.
REQ-003 clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_done  input  1  one-cycle pulse: camera finished writing bank wr_bank.
REQ-006 wr_bank  output  1  bank the camera writer currently fills.
REQ-007 sf_bank  output  1  bank the spot finder reads; it is the upper block-RAM address bit.
REQ-008 sf_start  output  1  one-cycle pulse: spot finder begins analysis of sf_bank.
REQ-009 sf_abort  output  1  one-cycle pulse: spot finder returns to its reset state.
REQ-010 sf_rdy  input  1  analysis-complete pulse from the spot finder.
REQ-011 sf_num_rois  input  8  ROI count from the spot finder.
REQ-012 sf_rois  input  NUM_ROIS_MAX*40  packed ROIs {xs,ys,xe,ye}, 10 bits each.
REQ-013 rois_out  output  NUM_ROIS_MAX*40  ROIs of the last completed frame.
REQ-014 num_rois_out  output  8  ROI count of the last completed frame.
REQ-015 rois_valid  output  1  one-cycle pulse when rois_out and num_rois_out update.
REQ-016 frames_dropped  output  16  saturating count of frames not analysed.
REQ-017 timeout_err  output  1  sticky flag set by a watchdog abort.

Function
REQ-018 States: IDLE, START, BUSY, PUBLISH; an encoding other than these four SHALL go to IDLE.
REQ-019 IDLE + frame_done: next cycle wr_bank toggles, sf_bank takes the old wr_bank, and the state becomes START.
REQ-020 START: sf_start SHALL be high for exactly this one cycle; next state is BUSY.
REQ-021 BUSY: remain until sf_rdy=1, then go to PUBLISH.
REQ-022 PUBLISH: rois_out<=sf_rois, num_rois_out<=min(sf_num_rois,NUM_ROIS_MAX), rois_valid=1 for one cycle; next state IDLE.
REQ-023 frame_done in PUBLISH SHALL be handled as in IDLE: bank swap, next state START; results are still published.
REQ-024 frame_done in START or BUSY: no bank swap; the camera overwrites the same bank; frames_dropped increments and saturates at 16'hFFFF.
REQ-025 sf_rdy outside BUSY SHALL be ignored.
REQ-026 wr_bank and sf_bank SHALL differ in every cycle while in START, BUSY or PUBLISH.
REQ-027 Latency: frame_done at cycle N in IDLE gives sf_start at N+1; sf_rdy at cycle M gives rois_valid at M+1.
REQ-028 rois_out and num_rois_out SHALL hold their values between rois_valid pulses.

Reset
REQ-029 Reset values: state IDLE, wr_bank=0, sf_bank=1, sf_start=0, sf_abort=0, rois_out=0, num_rois_out=0, rois_valid=0, frames_dropped=0, timeout_err=0.
REQ-030 Reset during BUSY SHALL drop the analysis with no rois_valid pulse; sf_abort stays 0, because the spot finder shares the same reset.

Configuration
REQ-031 Macro SPOT_SCHED_TIMEOUT_EN defined: a cycle counter runs in BUSY and clears on entering BUSY.
REQ-032 With the macro, reaching TIMEOUT_CYCLES causes, on the next cycle, sf_abort=1 for one cycle, timeout_err=1 (sticky until reset), state IDLE, and no publish.
REQ-033 With the macro, sf_rdy and timeout in the same cycle: sf_rdy wins and the block goes to PUBLISH.
REQ-034 Macro undefined: no counter exists, sf_abort=0 and timeout_err=0 constantly, and BUSY waits indefinitely.

Structure
REQ-035 Package spot_sched_pkg SHALL hold the state typedef, ROI_COORD_BITS=10, ROI_BITS=40 and the default NUM_ROIS_MAX.
REQ-036 Sub-module spot_watchdog (counter, clear, expire pulse) SHALL be instantiated only under SPOT_SCHED_TIMEOUT_EN.

Verification
REQ-037 After reset, frame_done at cycle 10 -> wr_bank=1, sf_bank=0, sf_start pulse at cycle 11.
REQ-038 sf_rdy with sf_num_rois=3 and ROI0={5,5,11,11} -> rois_valid next cycle, num_rois_out=3, rois_out[39:0] matches.
REQ-039 Three frame_done pulses while in BUSY -> frames_dropped=3 and wr_bank unchanged.
REQ-040 frame_done coincident with PUBLISH -> rois_valid pulse, banks swap, sf_start on the following cycle.
REQ-041 With the macro and TIMEOUT_CYCLES=50, no sf_rdy -> sf_abort one cycle after cycle 50 of BUSY, timeout_err=1, state IDLE, no rois_valid.
REQ-042 Reset asserted in BUSY, then sf_rdy pulsed -> all outputs at reset values and no rois_valid.
